fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_push_arbiter_if.sv | 30 +++
 rtl/fifo_push_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Handshake bundle between the producers, the consumer and the shared-FIFO
// push arbiter. The master side drives requests, data and pops; the slave
// side (the arbiter) returns grants, the push strobe and FIFO status.
interface fifo_push_arbiter_if #(
    parameter int bits  = 4,
    parameter int depth = 8,
    parameter int n_req = 4
);
    localparam int cw = $clog2(depth) + 1;

    logic [n_req-1:0]      req;
    logic [n_req*bits-1:0] data_in;
    logic                  pop;
    logic [n_req-1:0]      gnt;
    logic                  push_out;
    logic [bits-1:0]       data_out;
    logic [cw-1:0]         count;
    logic                  full;
    logic                  empty;

    modport master (
        output req, data_in, pop,
        input  gnt, push_out, data_out, count, full, empty
    );

    modport slave (
        input  req, data_in, pop,
        output gnt, push_out, data_out, count, full, empty
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that lets several producers share one FIFO push port.
// The grant is combinational so a request is pushed in the same cycle; the
// block also tracks FIFO occupancy so it can refuse pushes while full and
// ignore pops while empty.
module fifo_push_arbiter #(
    parameter int bits  = 4,
    parameter int depth = 8,
    parameter int n_req = 4
) (
    input logic                clk,
    input logic                reset,
    fifo_push_arbiter_if.slave bus
);
    localparam int cw = $clog2(depth) + 1;
    localparam int pw = (n_req > 1) ? $clog2(n_req) : 1;
    localparam logic [cw-1:0] depth_c = cw'(depth);
    localparam logic [pw-1:0] last_c  = pw'(n_req - 1);

    logic [pw-1:0]    rr_ptr_q, rr_ptr_d;
    logic [cw-1:0]    count_q, count_d;
    logic [n_req-1:0] gnt;
    logic [pw-1:0]    grant_idx;
    logic             found;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop_eff;
    logic [bits-1:0]  data_sel;

    // Occupancy status decoded straight from the counter.
    always_comb begin
        full  = (count_q == depth_c);
        empty = (count_q == '0);
    end

    // Search upward from the round-robin pointer, wrapping, for the first requester.
    always_comb begin
        gnt       = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (!reset && !full) begin
            for (int k = 0; k < n_req; k++) begin
                if (!found && bus.req[pw'((int'(rr_ptr_q) + k) % n_req)]) begin
                    found     = 1'b1;
                    grant_idx = pw'((int'(rr_ptr_q) + k) % n_req);
                end
            end
        end
        if (found) begin
            gnt[grant_idx] = 1'b1;
        end
    end

    // Route the granted producer's slice to the FIFO, zero when nobody is granted.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < n_req; i++) begin
            if (gnt[i]) begin
                data_sel = bus.data_in[i*bits +: bits];
            end
        end
    end

    // Next pointer and occupancy: the pointer moves past the winner, count tracks push/pop.
    always_comb begin
        push     = found;
        pop_eff  = bus.pop && !empty;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        if (push) begin
            rr_ptr_d = (grant_idx == last_c) ? '0 : grant_idx + 1'b1;
        end
        case ({push, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset that clears occupancy and restarts the search at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.gnt      = gnt;
        bus.push_out = push;
        bus.data_out = data_sel;
        bus.count    = count_q;
        bus.full     = full;
        bus.empty    = empty;
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: a directed vector table, a few hand-written
// multi-cycle sequences, then randomized traffic compared against a
// queue-based reference model.
module tb_fifo_push_arbiter;
    localparam int BITS  = 4;
    localparam int DEPTH = 8;
    localparam int NREQ  = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fifo_push_arbiter_if #(.bits(BITS), .depth(DEPTH), .n_req(NREQ)) bus ();

    fifo_push_arbiter #(.bits(BITS), .depth(DEPTH), .n_req(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       pop;
        logic [3:0] gnt;
        logic       push;
        logic [3:0] dout;
        int         count;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vq[$];

    // Reference model state: FIFO contents as a queue plus the priority pointer.
    logic [3:0] model_q[$];
    int         model_ptr;

    task automatic addVec(input logic rst, input logic [3:0] req, input logic pop,
                          input logic [3:0] gnt, input logic push, input logic [3:0] dout,
                          input int count, input logic full, input logic empty);
        vec_t v;
        v.rst = rst; v.req = req; v.pop = pop; v.gnt = gnt; v.push = push;
        v.dout = dout; v.count = count; v.full = full; v.empty = empty;
        vq.push_back(v);
    endtask

    // Drive inputs just after the falling edge and let the combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic [3:0] req,
                                 input logic [15:0] data, input logic pop);
        @(negedge clk);
        reset       = rst;
        bus.req     = req;
        bus.data_in = data;
        bus.pop     = pop;
        #1;
    endtask

    task automatic checkOne(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] gnt, input logic push,
                               input logic [3:0] dout, input int count,
                               input logic full, input logic empty);
        checkOne({tag, ".gnt"},      int'(bus.gnt),      int'(gnt));
        checkOne({tag, ".push_out"}, int'(bus.push_out), int'(push));
        checkOne({tag, ".data_out"}, int'(bus.data_out), int'(dout));
        checkOne({tag, ".count"},    int'(bus.count),    count);
        checkOne({tag, ".full"},     int'(bus.full),     int'(full));
        checkOne({tag, ".empty"},    int'(bus.empty),    int'(empty));
    endtask

    task automatic stepEdge();
        @(posedge clk);
    endtask

    // Model: which producer wins this cycle, or -1.
    function automatic int modelGrant(input logic rst, input logic [3:0] req);
        if (rst || model_q.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelEdge(input logic rst, input logic [3:0] req,
                             input logic [15:0] data, input logic pop);
        int g;
        g = modelGrant(rst, req);
        if (rst) begin
            model_q.delete();
            model_ptr = 0;
        end else begin
            if (pop && model_q.size() > 0) void'(model_q.pop_front());
            if (g >= 0) begin
                model_q.push_back(data[g*4 +: 4]);
                model_ptr = (g + 1) % NREQ;
            end
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  r;
        logic        p;
        logic        rs;
        int          g;
        logic [3:0]  eg;
        logic [3:0]  ed;

        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;
        bus.pop     = 1'b0;
        d           = 16'hDCBA;

        // Directed table: rotation, single producer, simultaneous push/pop, fill and drain at full.
        addVec(1, 4'b1111, 1, 4'b0000, 0, 4'h0, 0, 0, 1);
        addVec(0, 4'b1111, 0, 4'b0001, 1, 4'hA, 0, 0, 1);
        addVec(0, 4'b1111, 0, 4'b0010, 1, 4'hB, 1, 0, 0);
        addVec(0, 4'b1111, 0, 4'b0100, 1, 4'hC, 2, 0, 0);
        addVec(0, 4'b1111, 0, 4'b1000, 1, 4'hD, 3, 0, 0);
        addVec(0, 4'b0100, 0, 4'b0100, 1, 4'hC, 4, 0, 0);
        addVec(0, 4'b0100, 0, 4'b0100, 1, 4'hC, 5, 0, 0);
        addVec(0, 4'b0100, 0, 4'b0100, 1, 4'hC, 6, 0, 0);
        addVec(0, 4'b0010, 1, 4'b0010, 1, 4'hB, 7, 0, 0);
        addVec(0, 4'b0000, 1, 4'b0000, 0, 4'h0, 7, 0, 0);
        addVec(0, 4'b0001, 0, 4'b0001, 1, 4'hA, 6, 0, 0);
        addVec(0, 4'b0001, 0, 4'b0001, 1, 4'hA, 7, 0, 0);
        addVec(0, 4'b0001, 0, 4'b0000, 0, 4'h0, 8, 1, 0);
        addVec(0, 4'b0001, 1, 4'b0000, 0, 4'h0, 8, 1, 0);
        addVec(0, 4'b0001, 0, 4'b0001, 1, 4'hA, 7, 0, 0);

        applyStimulus(1, 4'b0000, 16'h0000, 0);
        stepEdge();
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].rst, vq[i].req, d, vq[i].pop);
            checkOutput($sformatf("vec%0d", i), vq[i].gnt, vq[i].push, vq[i].dout,
                        vq[i].count, vq[i].full, vq[i].empty);
            stepEdge();
        end

        // Underflow: pops on an empty FIFO leave count at zero.
        applyStimulus(1, 4'b0000, d, 0);
        stepEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b0000, d, 1);
            checkOutput($sformatf("underflow%0d", i), 4'b0000, 0, 4'h0, 0, 0, 1);
            stepEdge();
        end
        applyStimulus(0, 4'b0000, d, 0);
        checkOutput("underflow_after", 4'b0000, 0, 4'h0, 0, 0, 1);

        // Reset mid-run: build count=5 with pointer at 3, then reset and restart from index 0.
        stepEdge();
        applyStimulus(0, 4'b0100, d, 0);
        checkOutput("mid_p2", 4'b0100, 1, 4'hC, 0, 0, 1);
        stepEdge();
        applyStimulus(0, 4'b1111, d, 0);
        checkOutput("mid_p3", 4'b1000, 1, 4'hD, 1, 0, 0);
        stepEdge();
        applyStimulus(0, 4'b1111, d, 0);
        checkOutput("mid_p0", 4'b0001, 1, 4'hA, 2, 0, 0);
        stepEdge();
        applyStimulus(0, 4'b1111, d, 0);
        checkOutput("mid_p1", 4'b0010, 1, 4'hB, 3, 0, 0);
        stepEdge();
        applyStimulus(0, 4'b1111, d, 0);
        checkOutput("mid_p2b", 4'b0100, 1, 4'hC, 4, 0, 0);
        stepEdge();
        applyStimulus(1, 4'b1111, d, 1);
        checkOutput("mid_reset", 4'b0000, 0, 4'h0, 5, 0, 0);
        stepEdge();
        applyStimulus(0, 4'b1001, d, 0);
        checkOutput("mid_after", 4'b0001, 1, 4'hA, 0, 0, 1);
        stepEdge();

        // Randomized traffic against the queue model.
        applyStimulus(1, 4'b0000, d, 0);
        stepEdge();
        model_q.delete();
        model_ptr = 0;
        for (int i = 0; i < 600; i++) begin
            d  = 16'($urandom);
            r  = 4'($urandom);
            p  = ($urandom_range(0, 9) < 4);
            rs = ($urandom_range(0, 59) == 0);
            applyStimulus(rs, r, d, p);
            g  = modelGrant(rs, r);
            eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
            ed = (g >= 0) ? d[g*4 +: 4] : 4'h0;
            checkOutput($sformatf("rand%0d", i), eg, (g >= 0), ed, model_q.size(),
                        (model_q.size() == DEPTH), (model_q.size() == 0));
            modelEdge(rs, r, d, p);
            stepEdge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
